// File: rtl/alu_ctrl_issue_stage_pkg.sv
// Shared definitions for the ALU control issue stage.
//   - ALU operation codes consumed by the EX-stage ALU (4 bits)
//   - RV32I/M opcode, funct3 and funct7 field values used by the decoder
//   - alu_ctrl_word_t: the packed control word held in the output registers
package alu_pkg;

  localparam int ALU_XLEN = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_MUL  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [3:0]          alu_control;
    logic                use_imm;
    logic [ALU_XLEN-1:0] imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                illegal;
  } alu_ctrl_word_t;

  localparam int CTRL_W = $bits(alu_ctrl_word_t);

endpackage

// File: rtl/alu_ctrl_issue_stage_if.sv
// ID->EX handshake bundle for the ALU control issue stage.
//   ID side : in_valid, in_ready, instr
//   EX side : out_valid, out_ready, alu_control, use_imm, imm, rs1, rs2, rd, illegal
// master = the issue stage, slave = the surrounding ID/EX logic.
interface alu_ctrl_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      alu_control;
  logic            use_imm;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            illegal;

  modport master (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, alu_control, use_imm, imm, rs1, rs2, rd, illegal
  );

  modport slave (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_control, use_imm, imm, rs1, rs2, rd, illegal
  );
endinterface

// File: rtl/alu_ctrl_issue_stage_skid.sv
// pipe_skid_buffer: registered valid/ready stage with one skid entry.
//   clk, rst_n (sync, active-low), flush_i (drops both entries)
//   in_valid_i / in_ready_o / in_data_i   : upstream side, in_ready_o is a flop output
//   out_valid_o / out_ready_i / out_data_o: downstream side, driven straight from flops
module pipe_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept;
  logic             out_free;

  // The skid slot being occupied is the only reason to refuse input.
  assign accept   = in_valid_i && !skid_valid_q;
  // Output register may be overwritten when empty or being drained this edge.
  assign out_free = !out_valid_q || out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // A waiting skid entry has priority; in_ready was low so nothing new arrives.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_data_d = in_data_i;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  // ---- register stage ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/alu_ctrl_issue_stage.sv
// alu_ctrl_issue_stage: decodes RV32I/M instruction words into the ALU control word
// (alu_control, use_imm, imm, rs1/rs2/rd, illegal) and presents it registered to EX.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, dominates flush
//   flush : drops every buffered entry and any input offered in the same cycle
//   bus   : alu_ctrl_issue_stage_if.master carrying both handshakes and the control word
module alu_ctrl_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  alu_ctrl_issue_stage_if.master bus
);

  function automatic alu_ctrl_word_t decode(input logic [31:0] ins);
    alu_ctrl_word_t w;
    logic [6:0]     opc;
    logic [6:0]     f7;
    logic [2:0]     f3;
    logic           legal;
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    w     = '0;
    w.alu_control = ALU_ADD;
    w.rs1 = ins[19:15];
    w.rs2 = ins[24:20];
    w.rd  = ins[11:7];
    legal = 1'b0;
    case (opc)
      OPC_OP: begin
        legal = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD_SUB: w.alu_control = ALU_ADD;
            F3_SLL:     w.alu_control = ALU_SLL;
            F3_SLTU:    w.alu_control = ALU_SLTU;
            F3_XOR:     w.alu_control = ALU_XOR;
            F3_SR:      w.alu_control = ALU_SRL;
            F3_OR:      w.alu_control = ALU_OR;
            F3_AND:     w.alu_control = ALU_AND;
            default:    legal = 1'b0;  // signed SLT has no ALU code
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD_SUB) begin
          w.alu_control = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == F3_SR) begin
          w.alu_control = ALU_SRA;
        end else if (f7 == F7_MULDIV && f3 == F3_ADD_SUB && ENABLE_MUL) begin
          w.alu_control = ALU_MUL;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        legal     = 1'b1;
        w.use_imm = 1'b1;
        w.imm     = ALU_XLEN'($signed(ins[31:20]));
        case (f3)
          F3_ADD_SUB: w.alu_control = ALU_ADD;
          F3_SLTU:    w.alu_control = ALU_SLTU;
          F3_XOR:     w.alu_control = ALU_XOR;
          F3_OR:      w.alu_control = ALU_OR;
          F3_AND:     w.alu_control = ALU_AND;
          F3_SLL: begin
            w.alu_control = ALU_SLL;
            w.imm         = ALU_XLEN'(ins[24:20]);
            legal         = (f7 == F7_BASE);
          end
          F3_SR: begin
            w.imm = ALU_XLEN'(ins[24:20]);
            if (f7 == F7_BASE)     w.alu_control = ALU_SRL;
            else if (f7 == F7_ALT) w.alu_control = ALU_SRA;
            else                   legal = 1'b0;
          end
          default: legal = 1'b0;  // SLTI
        endcase
      end
      OPC_LOAD: begin
        legal     = 1'b1;
        w.use_imm = 1'b1;
        w.imm     = ALU_XLEN'($signed(ins[31:20]));
      end
      OPC_STORE: begin
        legal     = 1'b1;
        w.use_imm = 1'b1;
        w.imm     = ALU_XLEN'($signed({ins[31:25], ins[11:7]}));
      end
      OPC_BRANCH: begin
        // EX compares via SUB and the zero flag, so only equality branches fit.
        legal         = (f3 == F3_BEQ) || (f3 == F3_BNE);
        w.alu_control = ALU_SUB;
      end
      default: legal = 1'b0;
    endcase
    // Illegal words still travel down the pipe, with a neutral payload.
    if (!legal) begin
      w.alu_control = ALU_ADD;
      w.use_imm     = 1'b0;
      w.imm         = '0;
    end
    w.illegal = !legal;
    return w;
  endfunction

  alu_ctrl_word_t    dec_word;
  alu_ctrl_word_t    out_word;
  logic [CTRL_W-1:0] out_bits;

  assign dec_word = decode(bus.instr);

  // ---- decode -> registered output ----
  pipe_skid_buffer #(
    .WIDTH(CTRL_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .in_valid_i (bus.in_valid),
    .in_ready_o (bus.in_ready),
    .in_data_i  (dec_word),
    .out_valid_o(bus.out_valid),
    .out_ready_i(bus.out_ready),
    .out_data_o (out_bits)
  );

  assign out_word        = alu_ctrl_word_t'(out_bits);
  assign bus.alu_control = out_word.alu_control;
  assign bus.use_imm     = out_word.use_imm;
  assign bus.imm         = XLEN'($signed(out_word.imm));
  assign bus.rs1         = out_word.rs1;
  assign bus.rs2         = out_word.rs2;
  assign bus.rd          = out_word.rd;
  assign bus.illegal     = out_word.illegal;

endmodule
